seg7_capture_decoder: RTL and testbench

- Reverse direction of the team's hex-to-7-segment case decoders: reads a multiplexed 7-segment drive bus and recovers the hex digit shown on each display position.
- Samples are filtered for stability, checked against the legal hex glyph table, and committed per digit into output registers with update and error flags.
- Sits on the verification/readback side of the display path: a display scanner drives it, and the control logic or scoreboard consumes it.

---
 rtl/seg7_capture_decoder.sv | 170 +++++++++++++++++
 tb/tb_seg7_capture_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder
//   Reads a multiplexed 7-segment drive bus and recovers the hex digit shown
//   on each display position. Each sample is registered, routed to its
//   digit's filter, held until stable, then checked against the hex glyph
//   table and committed.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   seg[6:0]     segment drive a..g (seg[6]=a ... seg[0]=g), active-high
//   digit_sel    one-hot position strobe for the current seg value
//   sample_en    qualifies seg/digit_sel this cycle
//   hex_out      committed hex value; digit i at [4i+3:4i]
//   digit_valid  sticky: digit holds a committed legal glyph
//   digit_err    sticky: last commit for the digit was an illegal pattern
//   update       one-cycle pulse on any commit
//   update_idx   committed digit index (valid while update=1)
//   sel_err      one-cycle pulse for a sample with a non-one-hot digit_sel

// Per-digit stability filter and glyph decoder.
//   hit     a captured sample targets this digit this cycle
//   pat     captured segment pattern
//   hex     committed value, valid/err sticky flags
//   commit  combinational: this hit completes stability (registered by top)
module seg7_digit_filter #(
  parameter int STABLE_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic [6:0] pat,
  output logic [3:0] hex,
  output logic       valid,
  output logic       err,
  output logic       commit
);
  localparam logic [3:0] SC = 4'(STABLE_COUNT);

  logic [6:0] last_pat;
  logic [3:0] cnt, cnt_nxt;
  logic       match, sat, legal;
  logic [3:0] dec;

  always_comb begin
    match   = (pat == last_pat);
    sat     = (cnt == SC);
    cnt_nxt = match ? (sat ? cnt : cnt + 4'd1) : 4'd1;
    // A saturated run of the same pattern never recommits; a reload to 1
    // commits only when SC is 1.
    commit  = hit && (cnt_nxt == SC) && !(match && sat);
  end

  always_comb begin
    legal = 1'b1;
    dec   = 4'h0;
    case (pat)
      7'b1111110: dec = 4'h0;
      7'b0110000: dec = 4'h1;
      7'b1101101: dec = 4'h2;
      7'b1111001: dec = 4'h3;
      7'b0110011: dec = 4'h4;
      7'b1011011: dec = 4'h5;
      7'b1011111: dec = 4'h6;
      7'b1110000: dec = 4'h7;
      7'b1111111: dec = 4'h8;
      7'b1111011: dec = 4'h9;
      7'b1110111: dec = 4'hA;
      7'b0011111: dec = 4'hB;
      7'b1001110: dec = 4'hC;
      7'b0111101: dec = 4'hD;
      7'b1001111: dec = 4'hE;
      7'b1000111: dec = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pat <= '0;
      cnt      <= '0;
      hex      <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else if (hit) begin
      last_pat <= pat;
      cnt      <= cnt_nxt;
      if (commit) begin
        if (legal) begin
          hex   <= dec;
          valid <= 1'b1;
          err   <= 1'b0;
        end else begin
          err   <= 1'b1;
        end
      end
    end
  end
endmodule

module seg7_capture_decoder #(
  parameter int NUM_DIGITS   = 4,
  parameter int STABLE_COUNT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic                    sample_en,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    sel_err
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [6:0] pat;
    logic [2:0] idx;
  } smp_t;

  smp_t                            s1;
  logic [STAGES-1:0]               vld_pipe;
  logic [2:0]                      sel_idx;
  logic                            sel_oh;
  logic [NUM_DIGITS-1:0]           hit, commit;
  logic [NUM_DIGITS-1:0][3:0]      hex_q;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (digit_sel[i]) sel_idx = 3'(i);
    sel_oh = ($countones(digit_sel) == 1);
  end

  // Stage 1: capture; bad strobes are flagged and dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      s1         <= '0;
      sel_err    <= 1'b0;
      update     <= 1'b0;
      update_idx <= '0;
    end else begin
      vld_pipe[0] <= sample_en && sel_oh;
      sel_err     <= sample_en && !sel_oh;
      if (sample_en && sel_oh) s1 <= '{pat: seg, idx: sel_idx};
      // Only one digit can commit per cycle, so s1.idx names it.
      update <= |commit;
      if (|commit) update_idx <= s1.idx;
    end
  end

  // Stage 2: per-digit filters.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign hit[k] = vld_pipe[0] && (s1.idx == 3'(k));
    seg7_digit_filter #(.STABLE_COUNT(STABLE_COUNT)) u_flt (
      .clk    (clk),
      .reset  (reset),
      .hit    (hit[k]),
      .pat    (s1.pat),
      .hex    (hex_q[k]),
      .valid  (digit_valid[k]),
      .err    (digit_err[k]),
      .commit (commit[k])
    );
  end

  assign hex_out = hex_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder with a reference model and a
// timestamped scoreboard of expected outputs.
module tb_seg7_capture_decoder;
  localparam int N  = 4;
  localparam int SC = 3;

  logic           clk = 1'b0;
  logic           reset, sample_en;
  logic [6:0]     seg;
  logic [N-1:0]   digit_sel;
  logic [4*N-1:0] hex_out;
  logic [N-1:0]   digit_valid, digit_err;
  logic           update, sel_err;
  logic [2:0]     update_idx;

  seg7_capture_decoder #(.NUM_DIGITS(N), .STABLE_COUNT(SC)) dut (
    .clk(clk), .reset(reset), .seg(seg), .digit_sel(digit_sel),
    .sample_en(sample_en), .hex_out(hex_out), .digit_valid(digit_valid),
    .digit_err(digit_err), .update(update), .update_idx(update_idx),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    bit             upd;
    int             idx;
    logic [4*N-1:0] hex;
    logic [N-1:0]   vld;
    logic [N-1:0]   err;
  } exp_t;
  typedef struct {
    int due;
    bit se;
  } sexp_t;

  exp_t  q[$];
  sexp_t sq[$];
  int    tests = 0, fails = 0, cyc = 0;

  logic [6:0] m_last[N];
  int         m_cnt[N];
  logic [3:0] m_hex[N];
  bit         m_vld[N], m_err[N];
  logic [6:0] glyph[16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exv);
    tests++;
    assert (obs === exv) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exv);
    end
  endtask

  task automatic step(bit rst, bit en, logic [N-1:0] sel, logic [6:0] p);
    exp_t  e;
    sexp_t s;
    int    k;
    bit    oh, commit, legal;
    reset = rst; sample_en = en; digit_sel = sel; seg = p;
    commit = 0; k = 0;
    oh = ($countones(sel) == 1);
    if (rst) begin
      q.delete(); sq.delete();
      for (int i = 0; i < N; i++) begin
        m_last[i] = '0; m_cnt[i] = 0; m_hex[i] = '0; m_vld[i] = 0; m_err[i] = 0;
      end
    end else if (en && oh) begin
      for (int i = 0; i < N; i++) if (sel[i]) k = i;
      if (p == m_last[k]) begin
        if (m_cnt[k] < SC) begin
          m_cnt[k]++;
          commit = (m_cnt[k] == SC);
        end
      end else begin
        m_last[k] = p;
        m_cnt[k]  = 1;
        commit    = (SC == 1);
      end
      if (commit) begin
        legal = 0;
        for (int g = 0; g < 16; g++)
          if (glyph[g] == p) begin legal = 1; m_hex[k] = 4'(g); end
        if (legal) begin m_vld[k] = 1; m_err[k] = 0; end
        else m_err[k] = 1;
      end
    end
    s.due = cyc + 1; s.se = !rst && en && !oh;
    e.due = cyc + 2; e.upd = commit; e.idx = k;
    for (int i = 0; i < N; i++) begin
      e.hex[4*i +: 4] = m_hex[i]; e.vld[i] = m_vld[i]; e.err[i] = m_err[i];
    end
    sq.push_back(s);
    q.push_back(e);
    @(posedge clk); #1; cyc++;
    while (sq.size() != 0 && sq[0].due == cyc) begin
      s = sq.pop_front();
      chk("sel_err", 32'(sel_err), 32'(s.se));
    end
    while (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("update", 32'(update), 32'(e.upd));
      if (e.upd) chk("update_idx", 32'(update_idx), 32'(e.idx));
      chk("hex_out", 32'(hex_out), 32'(e.hex));
      chk("digit_valid", 32'(digit_valid), 32'(e.vld));
      chk("digit_err", 32'(digit_err), 32'(e.err));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  initial begin
    step(1, 0, '0, '0);
    step(1, 0, '0, '0);
    idle(2);
    // digit 0 shows 2
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0001, 7'b1101101);
    idle(3);
    // interleaved b on digit 1, C on digit 2
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'b0010, 7'b0011111);
      step(0, 1, 4'b0100, 7'b1001110);
    end
    idle(3);
    // bounce on digit 0: 0,0 then 1 x4 -> single commit of 1
    step(0, 1, 4'b0001, 7'b1111110);
    step(0, 1, 4'b0001, 7'b1111110);
    for (int i = 0; i < 4; i++) step(0, 1, 4'b0001, 7'b0110000);
    idle(3);
    // illegal on digit 3, then E clears the error
    for (int i = 0; i < 3; i++) step(0, 1, 4'b1000, 7'b1010101);
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1, 4'b1000, 7'b1001111);
    idle(2);
    // alternate 7 glyph is illegal; then legal 7
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0100, 7'b1110010);
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0100, 7'b1110000);
    idle(2);
    // bad strobes
    step(0, 1, 4'b0011, 7'b1111111);
    step(0, 1, 4'b0000, 7'b1111111);
    idle(3);
    // reset mid-run; sample during reset ignored; 3 fresh samples needed
    step(0, 1, 4'b0010, 7'b1111011);
    step(0, 1, 4'b0010, 7'b1111011);
    step(1, 1, 4'b0010, 7'b1111011);
    idle(2);
    step(0, 1, 4'b0010, 7'b1111011);
    step(0, 1, 4'b0010, 7'b1111011);
    idle(2);
    step(0, 1, 4'b0010, 7'b1111011);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
